// File: rtl/button_event_decoder.sv
// Turns the debounced button level into single-cycle press/release/click/long/double
// event pulses plus a registered "held" level; every output is a flop.
module button_event_decoder #(
    parameter int CLK_PERIOD_NS   = 10,
    parameter int LONG_PRESS_MS   = 1000,
    parameter int DOUBLE_CLICK_MS = 300
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clean_in,
    output logic press_pulse_out,
    output logic release_pulse_out,
    output logic short_press_out,
    output logic long_press_out,
    output logic double_click_out,
    output logic held_out
);

    localparam longint LONG_CYCLES_L = longint'(LONG_PRESS_MS) * 1_000_000 / CLK_PERIOD_NS;
    localparam longint GAP_CYCLES_L  = longint'(DOUBLE_CLICK_MS) * 1_000_000 / CLK_PERIOD_NS;
    localparam int     LONG_CYCLES   = int'(LONG_CYCLES_L);
    localparam int     GAP_CYCLES    = int'(GAP_CYCLES_L);
    localparam int     MAX_CYCLES    = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int     CNT_W         = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(GAP_CYCLES - 1);

    generate
        if (LONG_CYCLES < 2 || GAP_CYCLES < 2) begin : g_bad_params
            $error("button_event_decoder: LONG_CYCLES and GAP_CYCLES must both be >= 2");
        end
    endgenerate

    localparam logic [2:0] S_IDLE           = 3'd0;
    localparam logic [2:0] S_PRESSED        = 3'd1;
    localparam logic [2:0] S_LONG_HELD      = 3'd2;
    localparam logic [2:0] S_WAIT_GAP       = 3'd3;
    localparam logic [2:0] S_SECOND_PRESSED = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             double_q, double_d;
    logic             held_q, held_d;
    logic             rise, fall;

    assign rise = clean_in & ~prev_q;
    assign fall = ~clean_in & prev_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        double_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_PRESSED;
                end
            end
            S_PRESSED: begin
                // A release on the terminal-count edge beats the long press.
                if (fall) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_WAIT_GAP;
                end else if (cnt_q == LONG_TERM) begin
                    long_d  = 1'b1;
                    state_d = S_LONG_HELD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LONG_HELD: begin
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_WAIT_GAP: begin
                // A second press on the terminal-count edge beats the short click.
                if (rise) begin
                    press_d  = 1'b1;
                    double_d = 1'b1;
                    state_d  = S_SECOND_PRESSED;
                end else if (cnt_q == GAP_TERM) begin
                    short_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SECOND_PRESSED: begin
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d == S_PRESSED) || (state_d == S_LONG_HELD) ||
                 (state_d == S_SECOND_PRESSED);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            prev_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            double_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_q    <= clean_in;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            double_q  <= double_d;
            held_q    <= held_d;
        end
    end

    assign press_pulse_out   = press_q;
    assign release_pulse_out = release_q;
    assign short_press_out   = short_q;
    assign long_press_out    = long_q;
    assign double_click_out  = double_q;
    assign held_out          = held_q;

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Sits directly downstream of the button debouncer and consumes its clean, synchronous button level.
- Converts the level into single-cycle event pulses (press, release, short click, long press, double click) plus a held level.
- UI/control logic uses these outputs directly with no further edge detection.

Parameters:
- CLK_PERIOD_NS, 10, clock period in ns.
- LONG_PRESS_MS, 1000, hold time that qualifies as a long press.
- DOUBLE_CLICK_MS, 300, maximum release-to-press gap that still counts as a double click.
- Derived values:
  - LONG_CYCLES = LONG_PRESS_MS*1_000_000/CLK_PERIOD_NS.
  - GAP_CYCLES = DOUBLE_CLICK_MS*1_000_000/CLK_PERIOD_NS.
  - Both must be ≥2; elaboration error otherwise.
  - Counter width = $clog2(max(LONG_CYCLES, GAP_CYCLES)+1).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; asynchronous, active-high
- clean_in  input  1  debounced button level, synchronous to clk_in, 1 = pressed
- press_pulse_out  output  1  one-cycle pulse on each press
- release_pulse_out  output  1  one-cycle pulse on each release
- short_press_out  output  1  one-cycle pulse: single click confirmed
- long_press_out  output  1  one-cycle pulse: hold reached LONG_CYCLES
- double_click_out  output  1  one-cycle pulse: second press within gap window
- held_out  output  1  level: button currently pressed per FSM

Behaviour:
- Reset (asynchronous, active-high, no clock required):
  - State = IDLE, counter = 0, prev_q = 0.
  - All outputs 0, immediately on rst_in assertion.
  - If clean_in is already 1 after deassertion, the first edge treats it as a press.
- Edge detection: rise = clean_in & ~prev_q; fall = ~clean_in & prev_q. prev_q <= clean_in every edge.
- All outputs are registered. A pulse is high for exactly the one cycle after the sampling edge that triggers it. Latency = 1 cycle from clean_in change.
- States and transitions:
  - IDLE:
    - rise → press_pulse, counter=0, go to PRESSED.
  - PRESSED:
    - fall → release_pulse, counter=0, go to WAIT_GAP.
    - else if counter==LONG_CYCLES-1 → long_press pulse, go to LONG_HELD.
    - else counter++.
    - Result: long_press fires LONG_CYCLES edges after the press-sampling edge.
  - LONG_HELD:
    - fall → release_pulse, go to IDLE.
    - Never produces short or double.
  - WAIT_GAP:
    - rise → press_pulse and double_click pulse on the same cycle, go to SECOND_PRESSED.
    - else if counter==GAP_CYCLES-1 → short_press pulse, go to IDLE.
    - else counter++.
  - SECOND_PRESSED:
    - fall → release_pulse, go to IDLE.
    - No long-press detection; a third click starts a new sequence from IDLE.
- held_out = 1 in PRESSED, LONG_HELD and SECOND_PRESSED; 0 otherwise. Registered with the state.
- Boundary conditions:
  - Fall on the same edge the long terminal count would hit: release wins, no long_press.
  - Rise on the same edge the gap terminal count would hit: rise wins, double_click, no short_press.
  - The counter never exceeds its terminal value and never wraps.
  - At most one of short/long/double pulses per cycle.
  - press and double coincide only in the WAIT_GAP→SECOND_PRESSED transition.
  - rst_in mid-sequence: sequence discarded, no pending short_press emitted.

Test Plan:
- Parameters for all tests: CLK_PERIOD_NS=1_000_000, LONG_PRESS_MS=20, DOUBLE_CLICK_MS=10, giving LONG_CYCLES=20 and GAP_CYCLES=10.
- Reset with clean_in=0, assert rst_in between clock edges → all outputs 0 immediately; after release, 50 idle cycles → no pulses.
- Short click: clean_in high 5 cycles, then low → press pulse at edge k, held_out high k..k+4, release pulse at edge k+5, short_press at edge k+15; no long/double.
- Long press: clean_in high 30 cycles → press at k, long_press at k+20, held_out high throughout, release at k+30; no short_press follows.
- Double click: high 3, low 4, high 3, low → second press_pulse and double_click on the same cycle, release after each press; no short_press at any time.
- Boundaries:
  - Release exactly on edge k+20 → release only, no long_press.
  - Second rise exactly on gap edge 10 → double_click, no short_press.
  - Rise on gap edge 11 → short_press, then a new press_pulse.
- Async reset asserted in LONG_HELD with clean_in held high → held_out drops without a clock edge; after deassertion, press_pulse on the first edge.
